// File: rtl/select_button_conditioner.sv
// Conditions three raw pushbuttons into one-clock select command pulses:
// sync -> debounce -> rising-edge one-shot -> registered priority encoder.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat for next/prev.
module select_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20,
    parameter int REPEAT_CYCLES   = 25000000,
    parameter int RPT_WIDTH       = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_off,
    output logic [1:0] select,
    output logic [2:0] btn_level
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    // Bit order everywhere: [0] next, [1] prev, [2] off.
    logic [2:0]           raw;
    logic [2:0]           sync1;
    logic [2:0]           sync2;
    logic [2:0]           level;
    logic [2:0]           level_d;
    logic [2:0]           event_press;
    logic [2:0]           event_all;
    logic [CNT_WIDTH-1:0] cnt [3];

    assign raw = {btn_off, btn_prev, btn_next};

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level <= '0;
            for (int b = 0; b < 3; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 3; b++) begin
                if (sync2[b] == level[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_LAST) begin
                    level[b] <= ~level[b];
                    cnt[b]   <= '0;
                end else begin
                    cnt[b] <= cnt[b] + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign event_press = level & ~level_d;

`ifdef AUTO_REPEAT_EN
    localparam logic [RPT_WIDTH-1:0] RPT_LAST = RPT_WIDTH'(REPEAT_CYCLES - 1);

    logic [RPT_WIDTH-1:0] rpt_cnt [2];
    logic [1:0]           event_rpt;

    assign event_rpt = {level[1] && (rpt_cnt[1] == RPT_LAST),
                        level[0] && (rpt_cnt[0] == RPT_LAST)};
    assign event_all = event_press | {1'b0, event_rpt};

    // Any own event, won or lost, restarts the repeat period.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rpt_cnt[0] <= '0;
            rpt_cnt[1] <= '0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (!level[b] || event_all[b]) begin
                    rpt_cnt[b] <= '0;
                end else begin
                    rpt_cnt[b] <= rpt_cnt[b] + RPT_WIDTH'(1);
                end
            end
        end
    end
`else
    assign event_all = event_press;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_d <= '0;
            select  <= 2'b00;
        end else begin
            level_d <= level;
            if (event_all[2]) begin
                select <= 2'b11;
            end else if (event_all[1]) begin
                select <= 2'b01;
            end else if (event_all[0]) begin
                select <= 2'b10;
            end else begin
                select <= 2'b00;
            end
        end
    end

    assign btn_level = level;

endmodule
